// File: rtl/rib_rr_arbiter.sv
// Round-robin bus arbiter for the four RIB masters (m0 core load/store, m1 core fetch,
// m2 JTAG, m3 UART download). Picks the owner of the shared slave path, keeps the
// grant locked while the owner keeps requesting, and forces rotation once the owner
// has held the bus for MAX_HOLD cycles while someone else is waiting.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   req_i        request per master, bit n = master n
//   grant_o      registered one-hot grant, all zero when idle
//   grant_idx_o  index of granted master, holds its last value when idle
//   gnt_valid_o  1 while any grant is active
//   hold_flag_o  1 while m2 or m3 owns the bus (stalls the core pipeline)
module rib_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] grant_idx_o,
    output logic       gnt_valid_o,
    output logic       hold_flag_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_q;

    // Returns {found, index} of the first set bit of req, scanning start, start+1, ... mod 4.
    function automatic logic [2:0] first_from(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] n;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            n = start + 2'(i);
            if (req[n] && !res[2]) begin
                res = {1'b1, n};
            end
        end
        return res;
    endfunction

    logic [2:0] rr_win;     // winner of the ptr-based search (used from idle)
    logic [2:0] other_win;  // first requester after the current owner, owner excluded
    logic       take;
    logic [1:0] take_idx;

    always_comb begin
        rr_win    = first_from(req_i, ptr_q);
        other_win = first_from(req_i & ~(4'b0001 << idx_q), idx_q + 2'd1);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        take_idx = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (rr_win[2]) begin
                    take     = 1'b1;
                    take_idx = rr_win[1:0];
                end
            end
            StGrant: begin
                if (!req_i[idx_q]) begin
                    // Release wins over a coinciding timeout.
                    if (other_win[2]) begin
                        take     = 1'b1;
                        take_idx = other_win[1:0];
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        ptr_d   = idx_q + 2'd1;
                    end
                end else if ((cnt_q == CntMax) && other_win[2]) begin
                    take     = 1'b1;
                    take_idx = other_win[1:0];
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase

        if (take) begin
            state_d = StGrant;
            idx_d   = take_idx;
            grant_d = 4'b0001 << take_idx;
            ptr_d   = take_idx + 2'd1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            hold_q  <= grant_d[2] | grant_d[3];
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign gnt_valid_o = (state_q == StGrant);
    assign hold_flag_o = hold_q;

endmodule

// File: doc/rib_rr_arbiter.md
Name: rib_rr_arbiter

Overview:
- Round-robin bus arbiter for the four RIB masters: m0 core load/store, m1 core fetch, m2 JTAG, m3 UART download.
- Decides which master owns the shared slave path. Issues a registered one-hot grant and index to the RIB mux.
- Drives the hold flag that stalls the core pipeline while a non-core master owns the bus.
- A grant stays locked while the owner keeps requesting. A hold timeout forces rotation to prevent starvation.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one master keeps the grant while others wait (legal range 1..2^CNT_W-1).
- CNT_W, 5, width of the hold counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- req_i  input  4  request per master; bit n = master n
- grant_o  output  4  registered one-hot grant; all zero when idle
- grant_idx_o  output  2  index of granted master; holds last value when idle
- gnt_valid_o  output  1  1 when any grant is active
- hold_flag_o  output  1  1 when grant_o[2] or grant_o[3] is set; registered with grant_o

Behaviour:
- Reset: rst is asynchronous and active-low. While rst=0, all of the following are cleared immediately:
  - grant_o=4'b0000, grant_idx_o=2'd0, gnt_valid_o=0, hold_flag_o=0
  - rr pointer ptr=2'd0, hold counter cnt=0
- State machine states:
  - IDLE (gnt_valid_o=0)
  - GRANT (gnt_valid_o=1, owner g=grant_idx_o)
- Round-robin search: take the first requesting master in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE -> GRANT:
  - Any req_i bit set: at the next edge, grant the search winner and load cnt=0.
  - Latency from request to grant is 1 cycle.
- IDLE with req_i=0: stay in IDLE; ptr unchanged.
- GRANT, req_i[g]=1, and either cnt<MAX_HOLD-1 or no other request pending:
  - Keep g.
  - cnt increments and saturates at MAX_HOLD-1.
- GRANT, req_i[g]=1, cnt==MAX_HOLD-1, and another master requesting (timeout rotation):
  - At the next edge, grant the first other requester in order g+1, g+2, g+3.
  - cnt=0.
- GRANT, req_i[g]=0 (release):
  - If others are requesting: switch directly to the first requester in order g+1..g+3, with no idle bubble; cnt=0.
  - Otherwise go to IDLE.
- Simultaneous release and timeout in the same cycle: treated as a release.
- ptr update: on every grant change, ptr becomes new owner+1 (mod 4). On the move to IDLE, ptr becomes g+1.
- Grant rules:
  - At most one grant bit is set in any cycle.
  - A grant never changes except at a clock edge.
  - grant_o, grant_idx_o, gnt_valid_o and hold_flag_o all update on the same edge.
- hold_flag_o = grant_o[2] | grant_o[3], registered, no extra delay.
- Masters requesting while not granted wait; they have no drop/abort signalling. A requester's worst-case wait is 3*MAX_HOLD cycles.
- Reset mid-grant: all outputs drop asynchronously. After rst rises, arbitration restarts from IDLE with ptr=0.
- req_i is sampled only at rising clk edges; no combinational path from req_i to any output.

Test Plan:
- m2 alone: req_i=4'b0100 from IDLE -> next edge grant_o=4'b0100, grant_idx_o=2, gnt_valid_o=1, hold_flag_o=1. Drop req -> next edge all zero; ptr=3.
- Starvation check: MAX_HOLD=4, req_i=4'b1111 held constant after reset -> grant sequence m0,m1,m2,m3,m0, each owner exactly 4 cycles. hold_flag_o=1 only during the m2/m3 windows.
- Zero-bubble switch: m0 granted, req_i goes 4'b1001 -> 4'b1000 -> next edge grant_o=4'b1000 directly, gnt_valid_o stays 1.
- Lock with no contention: req_i=4'b0010 for 40 cycles, MAX_HOLD=16 -> grant_o=4'b0010 for all 40 cycles; cnt saturates at 15.
- Release at timeout: MAX_HOLD=4, m1 owner at cnt=3 drops req while m0 and m3 request -> next grant m3 (order 2,3,0); ptr=0.
- Reset mid-grant: m3 granted, pulse rst low between clock edges -> all outputs 0 immediately. After release with req_i=4'b1010 -> first grant m1.
